// File: rtl/rvga_ddr_arbiter_pkg.sv
// Shared types for the RVGA DDR arbiter: bus word/cacheline widths and the
// arbiter state enumeration.
package rvga_ddr_arbiter_pkg;

    typedef logic [31:0]  rvga_word;
    typedef logic [255:0] rvga_cacheline;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

endpackage

// File: rtl/rvga_ddr_arbiter.sv
// Two-requester (I-cache / D-cache) round-robin arbiter onto one DDR port.
// Optional statistics counters are built when RVGA_DDR_ARB_STATS_EN is defined.
module rvga_ddr_arbiter
    import rvga_ddr_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  rvga_word      icache_arb_addr,
    input  logic          icache_arb_read,
    output rvga_cacheline arb_icache_rdata,
    output logic          arb_icache_resp,
    input  rvga_word      dcache_arb_addr,
    input  logic          dcache_arb_read,
    input  logic          dcache_arb_write,
    input  rvga_cacheline dcache_arb_wdata,
    output rvga_cacheline arb_dcache_rdata,
    output logic          arb_dcache_resp,
    output rvga_word      arb_ddr_addr,
    output logic          arb_ddr_read,
    output logic          arb_ddr_write,
    output rvga_cacheline arb_ddr_wdata,
    input  rvga_cacheline ddr_arb_rdata,
    input  logic          ddr_arb_resp
`ifdef RVGA_DDR_ARB_STATS_EN
    ,
    output logic [31:0]   arb_i_grants,
    output logic [31:0]   arb_d_grants,
    output logic [31:0]   arb_conflict_cycles
`endif
);

    arb_state_e    r_state;
    arb_state_e    w_state_next;
    logic          r_last_grant;
    rvga_word      r_addr;
    logic          r_read;
    logic          r_write;
    rvga_cacheline r_wdata;

    logic          w_i_req;
    logic          w_d_req;
    logic          w_grant_i;
    logic          w_grant_d;

    assign w_i_req = icache_arb_read;
    assign w_d_req = dcache_arb_read | dcache_arb_write;

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (w_i_req && (!w_d_req || r_last_grant == SIDE_D)) begin
                    w_state_next = GRANT_I;
                    w_grant_i    = 1'b1;
                end else if (w_d_req) begin
                    w_state_next = GRANT_D;
                    w_grant_d    = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (ddr_arb_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= SIDE_D;
            r_addr       <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_i) begin
                r_last_grant <= SIDE_I;
                r_addr       <= icache_arb_addr;
                r_read       <= 1'b1;
                r_write      <= 1'b0;
                r_wdata      <= '0;
            end else if (w_grant_d) begin
                // A pending writeback takes precedence over a D-side read.
                r_last_grant <= SIDE_D;
                r_addr       <= dcache_arb_addr;
                r_read       <= dcache_arb_read & ~dcache_arb_write;
                r_write      <= dcache_arb_write;
                r_wdata      <= dcache_arb_wdata;
            end else if (r_state != IDLE && ddr_arb_resp) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
            end
        end
    end

    assign arb_ddr_addr     = r_addr;
    assign arb_ddr_read     = r_read;
    assign arb_ddr_write    = r_write;
    assign arb_ddr_wdata    = r_wdata;

    assign arb_icache_rdata = ddr_arb_rdata;
    assign arb_dcache_rdata = ddr_arb_rdata;
    assign arb_icache_resp  = (r_state == GRANT_I) & ddr_arb_resp;
    assign arb_dcache_resp  = (r_state == GRANT_D) & ddr_arb_resp;

`ifdef RVGA_DDR_ARB_STATS_EN
    logic w_conflict;

    // A requester that is asking but does not currently own the port is waiting.
    assign w_conflict = (w_i_req && r_state != GRANT_I) ||
                        (w_d_req && r_state != GRANT_D);

    always_ff @(posedge clk) begin
        if (!rst) begin
            arb_i_grants        <= '0;
            arb_d_grants        <= '0;
            arb_conflict_cycles <= '0;
        end else begin
            if (w_grant_i) arb_i_grants <= arb_i_grants + 32'd1;
            if (w_grant_d) arb_d_grants <= arb_d_grants + 32'd1;
            if (w_conflict) arb_conflict_cycles <= arb_conflict_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rvga_ddr_arbiter.sv
// Directed self-checking bench for rvga_ddr_arbiter with a transaction-level
// ownership model compared against the DUT every cycle.
module tb_rvga_ddr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icache_arb_addr;
    logic         icache_arb_read;
    logic [255:0] arb_icache_rdata;
    logic         arb_icache_resp;
    logic [31:0]  dcache_arb_addr;
    logic         dcache_arb_read;
    logic         dcache_arb_write;
    logic [255:0] dcache_arb_wdata;
    logic [255:0] arb_dcache_rdata;
    logic         arb_dcache_resp;
    logic [31:0]  arb_ddr_addr;
    logic         arb_ddr_read;
    logic         arb_ddr_write;
    logic [255:0] arb_ddr_wdata;
    logic [255:0] ddr_arb_rdata;
    logic         ddr_arb_resp;
`ifdef RVGA_DDR_ARB_STATS_EN
    logic [31:0]  arb_i_grants;
    logic [31:0]  arb_d_grants;
    logic [31:0]  arb_conflict_cycles;
`endif

    always #5 clk = ~clk;

    rvga_ddr_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .icache_arb_addr  (icache_arb_addr),
        .icache_arb_read  (icache_arb_read),
        .arb_icache_rdata (arb_icache_rdata),
        .arb_icache_resp  (arb_icache_resp),
        .dcache_arb_addr  (dcache_arb_addr),
        .dcache_arb_read  (dcache_arb_read),
        .dcache_arb_write (dcache_arb_write),
        .dcache_arb_wdata (dcache_arb_wdata),
        .arb_dcache_rdata (arb_dcache_rdata),
        .arb_dcache_resp  (arb_dcache_resp),
        .arb_ddr_addr     (arb_ddr_addr),
        .arb_ddr_read     (arb_ddr_read),
        .arb_ddr_write    (arb_ddr_write),
        .arb_ddr_wdata    (arb_ddr_wdata),
        .ddr_arb_rdata    (ddr_arb_rdata),
        .ddr_arb_resp     (ddr_arb_resp)
`ifdef RVGA_DDR_ARB_STATS_EN
        ,
        .arb_i_grants        (arb_i_grants),
        .arb_d_grants        (arb_d_grants),
        .arb_conflict_cycles (arb_conflict_cycles)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: who owns the DDR port (0 none, 1 I, 2 D), who won last, and the
    // request that was latched when ownership was handed out.
    int           m_owner;
    int           m_last;
    logic [31:0]  m_addr;
    logic         m_rd;
    logic         m_wr;
    logic [255:0] m_wdata;
    bit           m_iwant;
    bit           m_dwant;

    always @(posedge clk) begin
        if (!rst) begin
            m_owner = 0;
            m_last  = 2;
            m_addr  = '0;
            m_rd    = 1'b0;
            m_wr    = 1'b0;
            m_wdata = '0;
        end else if (m_owner == 0) begin
            m_iwant = icache_arb_read;
            m_dwant = dcache_arb_read || dcache_arb_write;
            if (m_iwant && (!m_dwant || m_last == 2)) begin
                m_owner = 1;
                m_last  = 1;
                m_addr  = icache_arb_addr;
                m_rd    = 1'b1;
                m_wr    = 1'b0;
            end else if (m_dwant) begin
                m_owner = 2;
                m_last  = 2;
                m_addr  = dcache_arb_addr;
                m_wr    = dcache_arb_write;
                m_rd    = !dcache_arb_write;
                m_wdata = dcache_arb_wdata;
            end
        end else if (ddr_arb_resp) begin
            m_owner = 0;
            m_rd    = 1'b0;
            m_wr    = 1'b0;
        end
    end

    int c_rd_hi = 0;
    int c_iresp = 0;
    int c_dresp = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ddr_read",  256'(arb_ddr_read),  256'(m_owner != 0 && m_rd));
            chk("ddr_write", 256'(arb_ddr_write), 256'(m_owner != 0 && m_wr));
            chk("ddr_rw_excl", 256'(arb_ddr_read && arb_ddr_write), 256'(1'b0));
            if (m_owner != 0) chk("ddr_addr", 256'(arb_ddr_addr), 256'(m_addr));
            if (m_owner != 0 && m_wr) chk("ddr_wdata", arb_ddr_wdata, m_wdata);
            chk("icache_resp", 256'(arb_icache_resp), 256'(m_owner == 1 && ddr_arb_resp));
            chk("dcache_resp", 256'(arb_dcache_resp), 256'(m_owner == 2 && ddr_arb_resp));
            chk("icache_rdata", arb_icache_rdata, ddr_arb_rdata);
            chk("dcache_rdata", arb_dcache_rdata, ddr_arb_rdata);
            if (arb_ddr_read)    c_rd_hi++;
            if (arb_icache_resp) c_iresp++;
            if (arb_dcache_resp) c_dresp++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_arb_addr  = '0;
        icache_arb_read  = 1'b0;
        dcache_arb_addr  = '0;
        dcache_arb_read  = 1'b0;
        dcache_arb_write = 1'b0;
        dcache_arb_wdata = '0;
        ddr_arb_rdata    = '0;
        ddr_arb_resp     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_req(output int waited, output bit ok);
        waited = 0;
        while (!(arb_ddr_read || arb_ddr_write) && waited < 20) begin
            tick();
            waited++;
        end
        ok = arb_ddr_read || arb_ddr_write;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_req: got no DDR request expected one within 20 cycles");
        end
    endtask

    // Serves one DDR transaction after lat cycles and reports who was answered.
    task automatic serve(input int lat, input logic [255:0] data, input bit drop,
                         output int who, output int waited, output logic rd,
                         output logic wr, output logic [31:0] addr);
        bit ok;
        who  = 0;
        rd   = 1'b0;
        wr   = 1'b0;
        addr = '0;
        wait_req(waited, ok);
        if (ok) begin
            rd   = arb_ddr_read;
            wr   = arb_ddr_write;
            addr = arb_ddr_addr;
            repeat (lat) tick();
            ddr_arb_resp  = 1'b1;
            ddr_arb_rdata = data;
            #1;
            who = arb_icache_resp ? 1 : (arb_dcache_resp ? 2 : 0);
            tick();
            ddr_arb_resp = 1'b0;
            if (drop && who == 1) icache_arb_read = 1'b0;
            if (drop && who == 2) begin
                dcache_arb_read  = 1'b0;
                dcache_arb_write = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int who, waited, b_rd, b_ip, b_dp;
        logic rd, wr;
        logic [31:0] addr;
        logic [255:0] a5, wd;
        int seq[6];
        int exp_seq[6];

        a5 = {32{8'hA5}};
        wd = {8{32'hC0DE_0200}};
        exp_seq = '{1, 2, 1, 2, 1, 2};

        // Reset state
        do_reset();
        chk("rst_ddr_read",  256'(arb_ddr_read),  256'(0));
        chk("rst_ddr_write", 256'(arb_ddr_write), 256'(0));
        chk("rst_ddr_addr",  256'(arb_ddr_addr),  256'(0));
        tick();

        // Single I read with 5-cycle DDR latency; address changes mid-grant
        b_rd = c_rd_hi; b_ip = c_iresp; b_dp = c_dresp;
        icache_arb_addr = 32'h0000_1000;
        icache_arb_read = 1'b1;
        tick();
        chk("i_latency_read", 256'(arb_ddr_read), 256'(1));
        chk("i_latency_addr", 256'(arb_ddr_addr), 256'(32'h0000_1000));
        icache_arb_addr = 32'hDEAD_BEEF;
        repeat (5) tick();
        chk("i_addr_hold", 256'(arb_ddr_addr), 256'(32'h0000_1000));
        ddr_arb_resp  = 1'b1;
        ddr_arb_rdata = a5;
        #1;
        chk("i_resp_pulse", 256'(arb_icache_resp), 256'(1));
        chk("i_resp_data",  arb_icache_rdata, a5);
        chk("i_dresp_zero", 256'(arb_dcache_resp), 256'(0));
        tick();
        ddr_arb_resp    = 1'b0;
        icache_arb_read = 1'b0;
        tick();
        chk("i_read_cycles", 256'(c_rd_hi - b_rd), 256'(6));
        chk("i_resp_count",  256'(c_iresp - b_ip), 256'(1));
        chk("i_dresp_count", 256'(c_dresp - b_dp), 256'(0));

        // Simultaneous I read and D write right after reset
        do_reset();
        icache_arb_addr  = 32'h0000_0100;
        icache_arb_read  = 1'b1;
        dcache_arb_addr  = 32'h0000_0200;
        dcache_arb_write = 1'b1;
        dcache_arb_wdata = wd;
        serve(3, a5, 1'b1, who, waited, rd, wr, addr);
        chk("tie_first_who",  256'(who),    256'(1));
        chk("tie_first_wait", 256'(waited), 256'(1));
        chk("tie_first_addr", 256'(addr),   256'(32'h0000_0100));
        serve(2, a5, 1'b1, who, waited, rd, wr, addr);
        chk("tie_second_who",  256'(who),    256'(2));
        chk("tie_second_idle", 256'(waited), 256'(1));
        chk("tie_second_wr",   256'(wr),     256'(1));
        chk("tie_second_rd",   256'(rd),     256'(0));
        chk("tie_second_addr", 256'(addr),   256'(32'h0000_0200));
        tick();

        // Both sides held for six transactions: strict alternation
        do_reset();
        icache_arb_addr = 32'h0000_0100;
        icache_arb_read = 1'b1;
        dcache_arb_addr = 32'h0000_0200;
        dcache_arb_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(1 + i, {8{32'(i)}}, (i == 5), who, waited, rd, wr, addr);
            seq[i] = who;
        end
        icache_arb_read = 1'b0;
        dcache_arb_read = 1'b0;
        for (int i = 0; i < 6; i++) chk("rr_order", 256'(seq[i]), 256'(exp_seq[i]));
`ifdef RVGA_DDR_ARB_STATS_EN
        chk("stats_i_grants", 256'(arb_i_grants), 256'(3));
        chk("stats_d_grants", 256'(arb_d_grants), 256'(3));
`endif
        tick();

        // D read and write together: write wins
        dcache_arb_addr  = 32'h0000_0300;
        dcache_arb_read  = 1'b1;
        dcache_arb_write = 1'b1;
        dcache_arb_wdata = ~wd;
        serve(2, a5, 1'b1, who, waited, rd, wr, addr);
        chk("rw_who",  256'(who),  256'(2));
        chk("rw_wr",   256'(wr),   256'(1));
        chk("rw_rd",   256'(rd),   256'(0));
        chk("rw_addr", 256'(addr), 256'(32'h0000_0300));
        tick();

        // Reset while D owns the port, then a late DDR response
        dcache_arb_addr  = 32'h0000_0400;
        dcache_arb_write = 1'b1;
        wait_req(waited, rd);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        dcache_arb_write = 1'b0;
        tick();
        ddr_arb_resp = 1'b1;
        #1;
        chk("late_iresp", 256'(arb_icache_resp), 256'(0));
        chk("late_dresp", 256'(arb_dcache_resp), 256'(0));
        chk("late_read",  256'(arb_ddr_read),    256'(0));
        chk("late_write", 256'(arb_ddr_write),   256'(0));
        tick();
        ddr_arb_resp = 1'b0;
        tick();

        // Spurious response with nobody asking
        ddr_arb_resp = 1'b1;
        #1;
        chk("spur_iresp", 256'(arb_icache_resp), 256'(0));
        chk("spur_dresp", 256'(arb_dcache_resp), 256'(0));
        tick();
        ddr_arb_resp = 1'b0;
        tick();
        chk("spur_read",  256'(arb_ddr_read),  256'(0));
        chk("spur_write", 256'(arb_ddr_write), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
